// File: rtl/robot_actuator.sv
// robot_actuator: turns one-cycle front/turn/remove requests into fixed-length drive pulses
//   in : clock, reset (async, active-low), front, turn, remove, abort (only with ROBOT_ACTUATOR_ABORT_EN)
//   out: motor_fwd, motor_rot, arm_out, busy, done, err (sticky), move_count, trash_count (saturating)
//   Optional: define ROBOT_ACTUATOR_ABORT_EN to add the abort input.
module robot_actuator #(
  parameter int FRONT_CYCLES  = 8,
  parameter int TURN_CYCLES   = 4,
  parameter int REMOVE_CYCLES = 6,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             front,
  input  logic             turn,
  input  logic             remove,
`ifdef ROBOT_ACTUATOR_ABORT_EN
  input  logic             abort,
`endif
  output logic             motor_fwd,
  output logic             motor_rot,
  output logic             arm_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] move_count,
  output logic [CNT_W-1:0] trash_count
);
  localparam int MAX_C = (FRONT_CYCLES > TURN_CYCLES) ?
                         ((FRONT_CYCLES > REMOVE_CYCLES) ? FRONT_CYCLES : REMOVE_CYCLES) :
                         ((TURN_CYCLES > REMOVE_CYCLES) ? TURN_CYCLES : REMOVE_CYCLES);
  localparam int CW = $clog2(MAX_C + 1);
  typedef enum logic [2:0] {IDLE, FWD, ROT, ARM, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] move_q, move_d, trash_q, trash_d;
  logic err_q, err_d, fwd_q, fwd_d, rot_q, rot_d, arm_q, arm_d, busy_q, busy_d, done_q, done_d;
  logic [1:0] n_req;
  logic abort_w;
`ifdef ROBOT_ACTUATOR_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    move_d  = move_q;
    trash_d = trash_q;
    n_req   = {1'b0, front} + {1'b0, turn} + {1'b0, remove};
    if (state_q == IDLE) begin
      if (n_req > 2'd1) err_d = 1'b1;
      else if (front) begin
        state_d = FWD;
        cnt_d   = CW'(FRONT_CYCLES - 1);
      end else if (turn) begin
        state_d = ROT;
        cnt_d   = CW'(TURN_CYCLES - 1);
      end else if (remove) begin
        state_d = ARM;
        cnt_d   = CW'(REMOVE_CYCLES - 1);
      end
    end else if (state_q == DONE) state_d = IDLE;
    else if (abort_w) state_d = IDLE;
    else if (cnt_q == '0) begin
      // counts update on the DONE entry edge so the new value shows during DONE
      state_d = DONE;
      if (state_q == FWD && !(&move_q)) move_d = move_q + 1'b1;
      if (state_q == ARM && !(&trash_q)) trash_d = trash_q + 1'b1;
    end else cnt_d = cnt_q - 1'b1;
    fwd_d  = state_d == FWD;
    rot_d  = state_d == ROT;
    arm_d  = state_d == ARM;
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      move_q  <= '0;
      trash_q <= '0;
      err_q   <= 1'b0;
      fwd_q   <= 1'b0;
      rot_q   <= 1'b0;
      arm_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      move_q  <= move_d;
      trash_q <= trash_d;
      err_q   <= err_d;
      fwd_q   <= fwd_d;
      rot_q   <= rot_d;
      arm_q   <= arm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign motor_fwd   = fwd_q;
  assign motor_rot   = rot_q;
  assign arm_out     = arm_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign move_count  = move_q;
  assign trash_count = trash_q;
endmodule
